floor_call_panel: RTL
=====================

# floor_call_panel

Request-side front end for the four-floor elevator controller. It debounces the four raw hall/cab call buttons and latches each press as a pending call. It presents exactly one target floor at a time to the elevator's one-hot floor-request input `F`, choosing the target by direction-preserving (SCAN) order. It clears a call once the elevator's current-floor output `Q` has matched the target for a programmable dwell time.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive enabled cycles a button must be stable before its new level is accepted (range 1..255).
- `ARRIVE_HOLD`, default 3: consecutive enabled cycles `Q` must equal `F` before the call is retired (range 1..255).

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: cycle enable, the same enable that drives the elevator. All state (debouncers, FSM, counters) advances only when `en`=1.
- `BTN` in 4: raw call buttons, bit i = floor i, active-high, asynchronous to `clk`.
- `Q` in 4: current floor from the elevator, one-hot.
- `F` out 4: registered one-hot floor request to the elevator. Zero means no request.
- `PENDING` out 4: registered call-lamp vector, one bit per latched call.
- `BUSY` out 1: high while in SERVE or CLEAR.

## Operation

- Input path:
  - `BTN` passes through a 2-flop synchronizer, which runs every cycle regardless of `en`.
  - Each bit then has its own debouncer: an 8-bit counter plus a stable level. When the synchronized value differs from the stable level, the counter increments on enabled cycles. When it equals the stable level, the counter resets to 0. When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter returns to 0.
  - A stable-level 0→1 transition is a press event, one enabled cycle wide.
- Latching:
  - A press on floor i sets `PENDING[i]`.
  - A press on the floor currently indicated by a valid `Q` while in IDLE is dropped, because the car is already there.
  - A press on a floor that is already pending has no effect.
- Direction register `dir` (1 = up) resets to up.
- FSM states: IDLE, SERVE, CLEAR.
  - **IDLE.** `F`=0. When `PENDING`≠0 and `Q` is one-hot, compute the current index c from `Q` and select target t:
    - if `dir`=up and any pending floor lies above c, t = nearest above;
    - otherwise, if any pending floor lies below c, t = nearest below and `dir` becomes down;
    - otherwise t = nearest above and `dir` becomes up.
    - The down direction is the mirror image of the up rule.
    - Register `F` = one-hot(t) and go to SERVE.
    - If `Q` is zero or has more than one bit set, remain in IDLE.
  - **SERVE.** `F` is held constant.
    - The hold counter increments on each enabled cycle with `Q`==`F` and resets to 0 on any enabled cycle with `Q`≠`F`.
    - When the counter reaches `ARRIVE_HOLD`, go to CLEAR.
    - New presses, including presses on other floors, still latch.
  - **CLEAR.** Clear `PENDING[t]`, drive `F`=0, and go to IDLE on the next enabled cycle.
    - A press on floor t in this same cycle is dropped, since the car is at t.
- `BUSY` = (state ≠ IDLE), registered.

## Timing

- Reset (asynchronous, takes effect immediately):
  - `F`=0, `PENDING`=0, `BUSY`=0.
  - state = IDLE, `dir` = up.
  - Hold counter and all debounce counters = 0.
  - Debounce stable levels = 0; synchronizer flops = 0.
- Reset asserted mid-SERVE drops all pending calls; nothing is retained.
- With `en`=1 continuously:
  - `BTN` rising edge → press event after 2 (sync) + `DEBOUNCE_CYCLES` cycles.
  - `PENDING` bit set 1 cycle after the press event.
  - `F` valid 1 cycle after `PENDING` first becomes nonzero in IDLE.
- Retirement: after `Q` first equals `F`, `F` returns to 0 and the `PENDING` bit clears `ARRIVE_HOLD`+1 enabled cycles later. The next target is presented 1 enabled cycle after that.
- `en`=0 freezes every register except the synchronizer. Outputs hold their values.
- Simultaneous events:
  - Presses on several floors in one cycle all latch.
  - A press on the target floor in the CLEAR cycle is dropped; clear wins.
- `F` never has more than one bit set, and never changes while in SERVE.

## Test plan

- **Reset:** assert `reset` mid-cycle with `BTN`=4'b1111 → `F`=0, `PENDING`=0, `BUSY`=0 immediately. After release, with `DEBOUNCE_CYCLES`=4, `PENDING`=4'b1111 at cycle 7.
- **Debounce:** pulse `BTN[2]` for 3 cycles, then for 4 cycles (`DEBOUNCE_CYCLES`=4) → the first pulse is ignored; the second sets `PENDING`=4'b0100.
- **Single call:** `Q`=4'b0001, press floor 3 → `F`=4'b1000 and `BUSY`=1. Drive `Q`=4'b1000 for 3 cycles → `F`=0 and `PENDING`=0 on the 4th cycle; `BUSY`=0 one cycle later.
- **SCAN order:** `Q`=4'b0010, `dir` up, `PENDING`=4'b1101 → service order floor 2, floor 3, then floor 0. `dir` switches to down when floor 0 is selected.
- **Hold reset:** in SERVE with target floor 1, drive `Q`=floor 1 for 2 cycles, then floor 2 for 1 cycle, then floor 1 for 3 cycles → retirement occurs only after the final 3-cycle run.
- **Enable / invalid Q:** `en`=0 for 10 cycles mid-SERVE → `F`, `PENDING` and the hold count are frozen. With `Q`=4'b0000 and `PENDING`≠0, the FSM stays in IDLE with `F`=0.

Source files
------------

// File: rtl/floor_call_panel.sv
// floor_call_panel: request-side front end for the four-floor elevator.
// Synchronizes and debounces the raw call buttons and latches presses as
// pending calls. It presents one target floor at a time on F, chosen in SCAN
// order, and retires a call once Q has matched F for ARRIVE_HOLD enabled cycles.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   en       cycle enable; everything except the synchronizer advances only when set
//   BTN[3:0] raw call buttons, bit i = floor i, asynchronous
//   Q[3:0]   current floor from the elevator, one-hot
//   F[3:0]   registered one-hot floor request (0 = no request)
//   PENDING  registered call-lamp vector
//   BUSY     registered, high while serving or clearing a call
module floor_call_panel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ARRIVE_HOLD     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] BTN,
  input  logic [3:0] Q,
  output logic [3:0] F,
  output logic [3:0] PENDING,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, SERVE, CLEAR} state_t;

  // The flip/retire decision is taken on the edge where the count would reach
  // its limit, so compare against limit-1.
  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(ARRIVE_HOLD - 1);

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [3:0]      press_q, press_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  state_t          state_q, state_d;
  logic            dir_q, dir_d;
  logic [7:0]      hold_q, hold_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      f_q, f_d;
  logic            busy_q, busy_d;

  // Debouncers: one counter and stable level per button.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
          press_d[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Call latching, target selection and retirement.
  logic        q_valid;
  int unsigned c_idx;
  logic [3:0]  above, below, ge, le;
  logic [3:0]  lo_above, lo_ge, hi_below, hi_le;
  logic [3:0]  drop;

  always_comb begin
    q_valid = (Q != '0) && ((Q & (Q - 4'd1)) == '0);
    c_idx   = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (Q[i]) c_idx = i;
    end

    above = '0;
    below = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      above[i] = pend_q[i] && (i > c_idx);
      below[i] = pend_q[i] && (i < c_idx);
    end
    // Calls at the current floor are only reached when nothing lies strictly
    // on either side; they are then served in place.
    ge = above | (pend_q & Q);
    le = below | (pend_q & Q);

    lo_above = above & (~above + 4'd1);
    lo_ge    = ge & (~ge + 4'd1);
    hi_below = '0;
    hi_le    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (below[i]) begin
        hi_below    = '0;
        hi_below[i] = 1'b1;
      end
      if (le[i]) begin
        hi_le    = '0;
        hi_le[i] = 1'b1;
      end
    end

    // Presses at the floor the car is already at are discarded.
    drop = '0;
    if (state_q == IDLE && q_valid) drop = Q;
    if (state_q == CLEAR)           drop = f_q;

    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    f_d     = f_q;
    pend_d  = pend_q | (press_q & ~drop);
    busy_d  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        f_d    = '0;
        hold_d = '0;
        if (pend_q != '0 && q_valid) begin
          state_d = SERVE;
          if (dir_q) begin
            if (above != '0) begin
              f_d = lo_above;
            end else if (below != '0) begin
              f_d   = hi_below;
              dir_d = 1'b0;
            end else begin
              f_d   = lo_ge;
              dir_d = 1'b1;
            end
          end else begin
            if (below != '0) begin
              f_d = hi_below;
            end else if (above != '0) begin
              f_d   = lo_above;
              dir_d = 1'b1;
            end else begin
              f_d   = hi_le;
              dir_d = 1'b0;
            end
          end
        end
      end
      SERVE: begin
        if (Q == f_q) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = CLEAR;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          hold_d = '0;
        end
      end
      CLEAR: begin
        pend_d  = pend_d & ~f_q;
        f_d     = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        f_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      dir_q    <= 1'b1;
      hold_q   <= '0;
      pend_q   <= '0;
      f_q      <= '0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
      if (en) begin
        stable_q <= stable_d;
        press_q  <= press_d;
        cnt_q    <= cnt_d;
        state_q  <= state_d;
        dir_q    <= dir_d;
        hold_q   <= hold_d;
        pend_q   <= pend_d;
        f_q      <= f_d;
        busy_q   <= busy_d;
      end
    end
  end

  assign F       = f_q;
  assign PENDING = pend_q;
  assign BUSY    = busy_q;

endmodule
